// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-SP22 core: opcodes, instruction field positions,
// scoreboard slot layout and hazard-controller FSM encoding.
package wisc_pkg;

    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned RT_LSB  = 5;
    localparam int unsigned RD_LSB  = 2;
    localparam int unsigned REG_W   = 3;

    localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SIIC = 5'b00010;
    localparam logic [OPC_W-1:0] OP_RTI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_J    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_JALR = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b10000;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b10001;
    localparam logic [OPC_W-1:0] OP_SLBI = 5'b10010;
    localparam logic [OPC_W-1:0] OP_STU  = 5'b10011;
    localparam logic [OPC_W-1:0] OP_LBI  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_BTR  = 5'b11001;

    localparam logic [REG_W-1:0] LINK_REG = 3'd7;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rnum;
    } sb_slot_t;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_RUN    = 2'd0;
    localparam fsm_state_t ST_DRAIN  = 2'd1;
    localparam fsm_state_t ST_HALTED = 2'd2;

    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    // True when an in-flight slot will write the given register.
    function automatic logic slot_hit(input sb_slot_t slot, input logic [REG_W-1:0] rnum);
        return slot.valid && (slot.rnum == rnum);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side control bundle between the pipeline and the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic [15:0]            id_instr;
    logic                   id_valid;
    logic                   ex_redirect;
    logic                   stall;
    logic                   bubble;
    logic                   flush;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_instr, id_valid, ex_redirect,
        input  stall, bubble, flush, halted, stall_cnt
    );

    modport slave (
        input  id_instr, id_valid, ex_redirect,
        output stall, bubble, flush, halted, stall_cnt
    );
endinterface

// File: rtl/reg_use_decode.sv
// Combinational register-usage decode: which sources an instruction reads and
// which register (if any) it writes.
module reg_use_decode
    import wisc_pkg::*;
(
    input  logic [15:0]      instr,
    output logic             rs_used,
    output logic [REG_W-1:0] rs,
    output logic             rt_used,
    output logic [REG_W-1:0] rt,
    output logic             dst_valid,
    output logic [REG_W-1:0] dst
);

    logic [OPC_W-1:0] opcode;
    logic             unused_lsb;

    assign opcode     = instr[OPC_LSB +: OPC_W];
    assign rs         = instr[RS_LSB +: REG_W];
    assign rt         = instr[RT_LSB +: REG_W];
    assign unused_lsb = ^instr[1:0];

    always_comb begin
        rs_used = 1'b1;
        case (opcode)
            OP_HALT, OP_NOP, OP_SIIC, OP_RTI, OP_J, OP_JAL, OP_LBI: rs_used = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        rt_used = 1'b0;
        casez (opcode)
            5'b1101?, 5'b111??, OP_ST, OP_STU: rt_used = 1'b1;
            default: ;
        endcase
    end

    // Destination field moves with the instruction format.
    always_comb begin
        dst_valid = 1'b0;
        dst       = instr[RD_LSB +: REG_W];
        casez (opcode)
            5'b1101?, 5'b111??, OP_BTR: begin
                dst_valid = 1'b1;
                dst       = instr[RD_LSB +: REG_W];
            end
            5'b010??, 5'b101??, OP_LD: begin
                dst_valid = 1'b1;
                dst       = instr[RT_LSB +: REG_W];
            end
            OP_STU, OP_SLBI, OP_LBI: begin
                dst_valid = 1'b1;
                dst       = instr[RS_LSB +: REG_W];
            end
            OP_JAL, OP_JALR: begin
                dst_valid = 1'b1;
                dst       = LINK_REG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW scoreboard over EX/MEM(/WB), redirect flush,
// and the HALT drain sequence for the five-stage WISC-SP22 core.
module hazard_ctrl
    import wisc_pkg::*;
#(
    parameter bit          WB_BYPASS   = 1'b1,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam bit WB_CHECK = (WB_BYPASS == 1'b0);

    logic             rs_used;
    logic             rt_used;
    logic             dst_valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;

    sb_slot_t   sb_ex;
    sb_slot_t   sb_mem;
    sb_slot_t   sb_wb;
    sb_slot_t   ex_load_c;

    fsm_state_t state;
    fsm_state_t state_nxt;
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_nxt;
    logic       halted_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic rs_hit_c;
    logic rt_hit_c;
    logic raw_c;
    logic halt_c;
    logic stall_c;
    logic bubble_c;
    logic flush_c;
    logic advance_c;
    logic count_raw_c;

    reg_use_decode u_decode (
        .instr     (bus.id_instr),
        .rs_used   (rs_used),
        .rs        (rs),
        .rt_used   (rt_used),
        .rt        (rt),
        .dst_valid (dst_valid),
        .dst       (dst)
    );

    // Decode compares only against older instructions, so a self-read never stalls.
    assign rs_hit_c = slot_hit(sb_ex, rs) | slot_hit(sb_mem, rs) | (WB_CHECK & slot_hit(sb_wb, rs));
    assign rt_hit_c = slot_hit(sb_ex, rt) | slot_hit(sb_mem, rt) | (WB_CHECK & slot_hit(sb_wb, rt));
    assign raw_c    = bus.id_valid & ((rs_used & rs_hit_c) | (rt_used & rt_hit_c));
    assign halt_c   = bus.id_valid & (bus.id_instr[OPC_LSB +: OPC_W] == OP_HALT);

    // Next-state and control decode; redirect outranks raw and HALT in RUN.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        stall_c       = 1'b0;
        bubble_c      = 1'b0;
        flush_c       = 1'b0;
        advance_c     = 1'b0;
        count_raw_c   = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.ex_redirect) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (raw_c) begin
                    stall_c     = 1'b1;
                    bubble_c    = 1'b1;
                    count_raw_c = 1'b1;
                end else begin
                    advance_c = bus.id_valid;
                    if (halt_c) begin
                        state_nxt     = ST_DRAIN;
                        drain_cnt_nxt = DRAIN_CYCLES;
                    end
                end
            end
            ST_DRAIN: begin
                stall_c       = 1'b1;
                bubble_c      = 1'b1;
                drain_cnt_nxt = 2'(drain_cnt - 2'd1);
                if (drain_cnt == 2'd1) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        ex_load_c.valid = advance_c & dst_valid;
        ex_load_c.rnum  = dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Scoreboard shift, sticky halted flag and saturating RAW-stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ex       <= '0;
            sb_mem      <= '0;
            sb_wb       <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            sb_ex    <= ex_load_c;
            sb_mem   <= sb_ex;
            sb_wb    <= sb_mem;
            halted_q <= (state_nxt == ST_HALTED);
            if (count_raw_c && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall_c & ~rst;
    assign bus.bubble    = bubble_c & ~rst;
    assign bus.flush     = flush_c & ~rst;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
